io_responder: RTL and testbench

Memory-mapped I/O responder on the CPU's memory port, the slave end of the address/write-enable/data bus the multicycle datapath drives toward memory. Decodes a 32-byte window, answers reads with the same one-cycle registered latency as the main memory, and accepts writes into a transmit FIFO and a compare timer. Read data is qualified by `sel` so the top level can mux it against memory output; the timer raises `irq` for the exception path.

---
 rtl/io_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_io_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
//   Memory-mapped I/O slave on the CPU memory port. Decodes a 32-byte window at
//   BASE_ADDR, answers reads one cycle after the address is presented (same
//   latency as main memory), pushes bytes into a transmit FIFO and runs an
//   optional compare timer that raises irq.
//
//   Build option: define IO_TIMER_EN to implement COUNT/CMP/tmr_flag/irq.
//   Without it the timer registers read 0, ignore writes and irq is tied low.
//
// Ports
//   clk       single clock, all state updates on the rising edge
//   reset     asynchronous, active-high; clears all state
//   address   byte address from the IorD mux
//   wr        write strobe
//   data_in   write data
//   data_out  registered read data, 0 when sel is low or on writes
//   sel       registered hit flag for the access presented last cycle
//   irq       timer interrupt request (CTRL[1] & tmr_flag)
//   tx_data   FIFO head byte
//   tx_valid  FIFO non-empty
//   tx_ready  consumer takes the head when high together with tx_valid
// -----------------------------------------------------------------------------
module io_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        wr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        sel,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_TXDATA = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_CMP    = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;

    logic             hit_s;
    logic [2:0]       idx_s;
    logic             wr_hit_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             ovf_set_s;
    logic             status_wr_s;
    logic [31:0]      status_s;
    logic [31:0]      rdata_s;
    logic [31:0]      rd_next_s;
    logic             unused_s;

    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             ovf_r;
    logic [31:0]      data_out_r;
    logic             sel_r;

    // Byte-lane bits and upper data bits are not decoded everywhere.
    assign unused_s = ^{address[1:0], data_in[31:8]};

    assign hit_s       = (address[31:5] == BASE_ADDR[31:5]);
    assign idx_s       = address[4:2];
    assign wr_hit_s    = wr & hit_s;
    assign status_wr_s = wr_hit_s & (idx_s == REG_STATUS);
    assign push_s      = wr_hit_s & (idx_s == REG_TXDATA);
    assign empty_s     = (level_r == '0);
    assign full_s      = (level_r == LVL_FULL);
    assign pop_s       = ~empty_s & tx_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok_s   = push_s & (~full_s | pop_s);
    assign ovf_set_s   = push_s & full_s & ~pop_s;

    assign tx_valid = ~empty_s;
    assign tx_data  = fifo_mem_r[rd_ptr_r];
    assign data_out = data_out_r;
    assign sel      = sel_r;

`ifdef IO_TIMER_EN
    logic [31:0] count_r;
    logic [31:0] cmp_r;
    logic [1:0]  ctrl_r;
    logic        tmr_flag_r;
    logic        count_wr_s;
    logic        tmr_hit_s;
    logic [31:0] count_next_s;

    assign count_wr_s = wr_hit_s & (idx_s == REG_COUNT);
    // A CPU write to COUNT replaces the compare/increment for that cycle.
    assign tmr_hit_s  = ctrl_r[0] & ~count_wr_s & (count_r == cmp_r);
    assign irq        = ctrl_r[1] & tmr_flag_r;

    // Next COUNT value: CPU write, compare restart, free increment or hold.
    always_comb begin
        count_next_s = count_r;
        if (count_wr_s) begin
            count_next_s = data_in;
        end else if (tmr_hit_s) begin
            count_next_s = 32'h0000_0000;
        end else if (ctrl_r[0]) begin
            count_next_s = count_r + 32'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // Timer registers; a compare hit beats a same-cycle W1C of the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r    <= 32'h0000_0000;
            cmp_r      <= 32'hFFFF_FFFF;
            ctrl_r     <= 2'b00;
            tmr_flag_r <= 1'b0;
        end else begin
            count_r <= count_next_s;
            if (wr_hit_s && (idx_s == REG_CMP)) begin
                cmp_r <= data_in;
            end else begin
                cmp_r <= cmp_r;
            end
            if (wr_hit_s && (idx_s == REG_CTRL)) begin
                ctrl_r <= data_in[1:0];
            end else begin
                ctrl_r <= ctrl_r;
            end
            if (tmr_hit_s) begin
                tmr_flag_r <= 1'b1;
            end else if (status_wr_s && data_in[3]) begin
                tmr_flag_r <= 1'b0;
            end else begin
                tmr_flag_r <= tmr_flag_r;
            end
        end
    end
`else
    assign irq = 1'b0;
`endif

    // STATUS word assembled from live FIFO and flag state.
    always_comb begin
        status_s               = 32'h0000_0000;
        status_s[0]            = empty_s;
        status_s[1]            = full_s;
        status_s[2]            = ovf_r;
`ifdef IO_TIMER_EN
        status_s[3]            = tmr_flag_r;
`endif
        status_s[8 +: LVL_W]   = level_r;
    end

    // Read mux over the register map; unmapped offsets read zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (idx_s)
            REG_STATUS: rdata_s = status_s;
`ifdef IO_TIMER_EN
            REG_COUNT:  rdata_s = count_r;
            REG_CMP:    rdata_s = cmp_r;
            REG_CTRL:   rdata_s = {30'h0000_0000, ctrl_r};
`endif
            default:    rdata_s = 32'h0000_0000;
        endcase
    end

    // Writes return zero data; only hitting reads carry register content.
    always_comb begin
        rd_next_s = 32'h0000_0000;
        if (hit_s && !wr) begin
            rd_next_s = rdata_s;
        end else begin
            rd_next_s = 32'h0000_0000;
        end
    end

    // Registered read port, one cycle behind the address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_r <= 32'h0000_0000;
            sel_r      <= 1'b0;
        end else begin
            data_out_r <= rd_next_s;
            sel_r      <= hit_s;
        end
    end

    // TX FIFO storage, pointers, level and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= data_in[7:0];
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (status_wr_s && data_in[2]) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// -----------------------------------------------------------------------------
// tb_io_responder
//   Self-checking bench for io_responder. Directed scenarios plus a randomized
//   run compared against a queue-based reference model of the register map.
//   Follows the IO_TIMER_EN define of the build.
// -----------------------------------------------------------------------------
module tb_io_responder;

    localparam logic [31:0] BASE  = 32'h0000_FF00;
    localparam int          DEPTH = 4;
`ifdef IO_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        wr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        sel;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0]  m_q[$];
    bit          m_ovf;
    bit          m_flag;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic [1:0]  m_ctrl;
    logic        exp_sel;
    logic [31:0] exp_dout;

    always #5 clk = ~clk;

    io_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .wr       (wr),
        .data_in  (data_in),
        .data_out (data_out),
        .sel      (sel),
        .irq      (irq),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_flag   = 1'b0;
        m_count  = 32'd0;
        m_cmp    = 32'hFFFF_FFFF;
        m_ctrl   = 2'b00;
        exp_sel  = 1'b0;
        exp_dout = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input int idx);
        int n;
        n = m_q.size();
        case (idx)
            0: return 32'((n == 0 ? 1 : 0) + (n == DEPTH ? 2 : 0) + (m_ovf ? 4 : 0)
                          + ((TMR && m_flag) ? 8 : 0) + n * 256);
            2: return TMR ? m_count : 32'd0;
            3: return TMR ? m_cmp : 32'd0;
            4: return TMR ? {30'd0, m_ctrl} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic r);
        bit hit, pop, push, cwr, match;
        int idx, n;
        hit   = (a[31:5] == BASE[31:5]);
        idx   = int'(a[4:2]);
        n     = m_q.size();
        pop   = r && (n > 0);
        push  = w && hit && (idx == 1);
        cwr   = w && hit && (idx == 2);
        exp_sel  = hit;
        exp_dout = (hit && !w) ? model_read(idx) : 32'd0;
        match = TMR && m_ctrl[0] && !cwr && (m_count == m_cmp);
        if (w && hit && idx == 0) begin
            if (d[2]) m_ovf = 1'b0;
            if (d[3]) m_flag = 1'b0;
        end
        if (push && n == DEPTH && !pop) m_ovf = 1'b1;
        if (match) m_flag = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (push && (n < DEPTH || pop)) m_q.push_back(d[7:0]);
        if (cwr) m_count = d;
        else if (m_ctrl[0]) m_count = match ? 32'd0 : m_count + 32'd1;
        if (w && hit && idx == 3) m_cmp = d;
        if (w && hit && idx == 4) m_ctrl = d[1:0];
    endtask

    // drive one bus cycle, advance the model, land 1 time unit past the edge
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic r);
        address  = a;
        wr       = w;
        data_in  = d;
        tx_ready = r;
        model_step(a, w, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; address = 32'd0; wr = 1'b0; data_in = 32'd0; tx_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks += 5;
        if (data_out !== 32'd0) begin n_fail++; $display("FAIL rst_data_out got %h want 0", data_out); end
        if (sel !== 1'b0)       begin n_fail++; $display("FAIL rst_sel got %b want 0", sel); end
        if (irq !== 1'b0)       begin n_fail++; $display("FAIL rst_irq got %b want 0", irq); end
        if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
        if (tx_data !== 8'd0)   begin n_fail++; $display("FAIL rst_tx_data got %h want 0", tx_data); end
        reset = 1'b0;
        step(BASE, 1'b0, 32'd0, 1'b0);
        n_checks += 2;
        if (sel !== 1'b1) begin n_fail++; $display("FAIL read_hit_sel got %b want 1", sel); end
        if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL read_status got %h want 00000001", data_out); end
        step(32'h0000_0100, 1'b0, 32'd0, 1'b0);
        n_checks += 2;
        if (sel !== 1'b0) begin n_fail++; $display("FAIL miss_sel got %b want 0", sel); end
        if (data_out !== 32'd0) begin n_fail++; $display("FAIL miss_data got %h want 0", data_out); end
    endtask

    task automatic test_fifo_order();
        step(BASE + 32'd4, 1'b1, 32'h41, 1'b0);
        n_checks += 2;
        if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL first_push_valid got %b want 1", tx_valid); end
        if (tx_data !== 8'h41) begin n_fail++; $display("FAIL first_push_head got %h want 41", tx_data); end
        step(BASE + 32'd4, 1'b1, 32'h42, 1'b0);
        step(BASE + 32'd4, 1'b1, 32'h43, 1'b0);
        step(BASE, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (data_out !== 32'h0000_0300) begin n_fail++; $display("FAIL status_lvl3 got %h want 00000300", data_out); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d] got valid=%b data=%h want valid=1 data=%h",
                         i, tx_valid, tx_data, 8'(8'h41 + i));
            end
            step(32'h0000_0100, 1'b0, 32'd0, 1'b1);
        end
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid got %b want 0", tx_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) step(BASE + 32'd4, 1'b1, 32'(i), 1'b0);
        step(BASE, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (data_out !== 32'h0000_0406) begin n_fail++; $display("FAIL ovf_status got %h want 00000406", data_out); end
        step(BASE, 1'b1, 32'h4, 1'b0);
        step(BASE, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (data_out !== 32'h0000_0402) begin n_fail++; $display("FAIL ovf_w1c got %h want 00000402", data_out); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_bytes [4];
        exp_bytes = '{8'h02, 8'h03, 8'h04, 8'h55};
        step(BASE + 32'd4, 1'b1, 32'h55, 1'b1);
        step(BASE, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (data_out !== 32'h0000_0402) begin n_fail++; $display("FAIL full_pushpop_status got %h want 00000402", data_out); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i]) begin
                n_fail++;
                $display("FAIL full_pushpop_drain[%0d] got valid=%b data=%h want valid=1 data=%h",
                         i, tx_valid, tx_data, exp_bytes[i]);
            end
            step(32'h0000_0100, 1'b0, 32'd0, 1'b1);
        end
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_empty got %b want 0", tx_valid); end
    endtask

`ifdef IO_TIMER_EN
    task automatic test_timer();
        logic [31:0] exp_cnt [5];
        exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        step(BASE + 32'd12, 1'b1, 32'd3, 1'b0);
        step(BASE + 32'd8,  1'b1, 32'd0, 1'b0);
        step(BASE + 32'd16, 1'b1, 32'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(BASE + 32'd8, 1'b0, 32'd0, 1'b0);
            n_checks += 2;
            if (data_out !== exp_cnt[i]) begin n_fail++; $display("FAIL count_seq[%0d] got %h want %h", i, data_out, exp_cnt[i]); end
            if (irq !== (i >= 3)) begin n_fail++; $display("FAIL irq_seq[%0d] got %b want %b", i, irq, (i >= 3)); end
        end
        step(BASE, 1'b1, 32'h8, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL flag_w1c got %b want 0", irq); end
        step(32'h0000_0100, 1'b0, 32'd0, 1'b0);
        step(BASE, 1'b1, 32'h8, 1'b0);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear got %b want 1", irq); end
        step(BASE, 1'b1, 32'h8, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL flag_w1c2 got %b want 0", irq); end
        step(BASE + 32'd16, 1'b1, 32'd0, 1'b0);
    endtask
`else
    task automatic test_timer();
        step(BASE + 32'd8, 1'b1, 32'd5, 1'b0);
        step(BASE + 32'd8, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (data_out !== 32'd0) begin n_fail++; $display("FAIL notimer_count got %h want 0", data_out); end
        step(BASE + 32'd16, 1'b1, 32'd3, 1'b0);
        step(BASE + 32'd16, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (data_out !== 32'd0) begin n_fail++; $display("FAIL notimer_ctrl got %h want 0", data_out); end
        for (int i = 0; i < 8; i++) begin
            step(32'h0000_0100, 1'b0, 32'd0, 1'b0);
            n_checks++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL notimer_irq got %b want 0", irq); end
        end
    endtask
`endif

    task automatic test_reset_midop();
        step(BASE + 32'd4, 1'b1, 32'hA5, 1'b0);
        step(BASE + 32'd4, 1'b1, 32'h5A, 1'b0);
        address = 32'h0000_0100; wr = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_checks += 2;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midop_rst_valid got %b want 0", tx_valid); end
        if (tx_data !== 8'd0)  begin n_fail++; $display("FAIL midop_rst_data got %h want 0", tx_data); end
        #1 reset = 1'b0;
        model_reset();
        step(BASE, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL midop_status got %h want 00000001", data_out); end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        w, r;
        int          idx;
        for (int cyc = 0; cyc < 600; cyc++) begin
            idx = int'($urandom_range(0, 9));
            if (idx == 9) begin
                a = $urandom;
                if (a[31:5] == BASE[31:5]) a = a ^ 32'h8000_0000;
            end else begin
                if (idx > 7) idx = 1;
                a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            end
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (idx == 2 || idx == 3) d = 32'($urandom_range(0, 12));
            r = ($urandom_range(0, 2) == 0);
            step(a, w, d, r);
            n_checks += 4;
            if (sel !== exp_sel) begin n_fail++; $display("FAIL rnd_sel cyc %0d got %b want %b", cyc, sel, exp_sel); end
            if (data_out !== exp_dout) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, data_out, exp_dout); end
            if (tx_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, tx_valid, (m_q.size() > 0)); end
            if (irq !== (TMR && m_ctrl[1] && m_flag)) begin n_fail++; $display("FAIL rnd_irq cyc %0d got %b want %b", cyc, irq, (TMR && m_ctrl[1] && m_flag)); end
            if (m_q.size() > 0) begin
                n_checks++;
                if (tx_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_head cyc %0d got %h want %h", cyc, tx_data, m_q[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_overflow();
        test_push_pop_full();
        test_timer();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
